// File: rtl/sym_fir_bs.sv
// sym_fir_bs -- symmetric FIR filter on a 1-bit sample stream.
//
// Bits shift continuously into a TAPS-deep sample line. A FILTER pulse
// snapshots the line. The block then accumulates one pre-added symmetric
// pair per cycle, rounds and saturates the sum, and pushes one result.
//
// Handshake: FILTER is a single-cycle start request that is accepted only
// while Busy=0. It is never queued. Every accepted start produces exactly
// one Push strobe, NC+3 edges after the accepting edge, unless Reset
// intervenes. Busy covers the whole run, including the Push cycle.
//
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-high reset
//   BitIn, BitValid     sample bit; it is shifted into s[0] when BitValid=1
//   FILTER              start pulse
//   CoefWe/Addr/Data    coefficient write port; writes only land while Busy=0
//   Dout                signed result, held until the next Push
//   Push                1-cycle strobe that marks a new Dout
//   Busy                run in progress; FILTER and coefficient writes are dropped
//   dbg_state           current FSM state, for observation
module sym_fir_bs #(
  parameter int TAPS    = 512,
  parameter int COEF_W  = 16,
  parameter int DOUT_W  = 16,
  parameter int SHIFT   = 8,
  parameter int BIPOLAR = 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          BitIn,
  input  logic                          BitValid,
  input  logic                          FILTER,
  input  logic                          CoefWe,
  input  logic [$clog2(TAPS/2)-1:0]     CoefAddr,
  input  logic signed [COEF_W-1:0]      CoefData,
  output logic signed [DOUT_W-1:0]      Dout,
  output logic                          Push,
  output logic                          Busy,
  output logic [2:0]                    dbg_state
);

  localparam int NC    = TAPS / 2;
  localparam int AW    = $clog2(NC);
  // This width holds the worst case 2*NC*|c|max, so the sum never wraps.
  localparam int ACC_W = COEF_W + 2 + AW;
  // The rounding path is wide enough for the sum plus the rounding constant,
  // and it can also represent both saturation limits.
  localparam int RW    = (ACC_W + 1 > DOUT_W + 1) ? ACC_W + 1 : DOUT_W + 1;

  localparam logic [AW:0]          NC_V    = NC[AW:0];
  localparam logic [AW-1:0]        K_LAST  = NC_V[AW-1:0] - 1'b1;
  localparam logic signed [RW-1:0] ONE     = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] SAT_MAX = (ONE <<< (DOUT_W - 1)) - ONE;
  localparam logic signed [RW-1:0] SAT_MIN = -(ONE <<< (DOUT_W - 1));
  // The rounding constant is half an LSB of the output, or 0 when SHIFT=0.
  localparam logic signed [RW-1:0] RND     = (ONE << SHIFT) >> 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                   state, state_next;
  logic [TAPS-1:0]          line;
  logic [TAPS-1:0]          snap;
  logic signed [COEF_W-1:0] coef [NC];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            k;
  logic signed [DOUT_W-1:0] result;

  logic                     b_lo, b_hi;
  logic signed [ACC_W-1:0]  c_ext, term;
  logic signed [RW-1:0]     acc_ext, rnd_sum, shifted;
  logic signed [DOUT_W-1:0] sat;

  // Push is registered in OUT, so it is high while the FSM is back in IDLE.
  // Counting that cycle as busy keeps Push cycles at least NC+4 apart.
  assign Busy      = (state != S_IDLE) || Push;
  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (FILTER && !Busy) state_next = S_LOAD;
      S_LOAD:  state_next = S_CALC;
      S_CALC:  if (k == K_LAST) state_next = S_ROUND;
      S_ROUND: state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pair term p(k)*c[k]. Each p value is a shift or a negation, so no
  // multiplier is needed.
  always_comb begin
    b_lo  = snap[k];
    b_hi  = snap[TAPS - 1 - int'(k)];
    c_ext = ACC_W'(coef[k]);
    term  = '0;
    if (BIPOLAR != 0) begin
      // x(b) is +1 or -1, so the pair is +2, -2, or 0 when the bits differ.
      if (b_lo && b_hi)        term = c_ext <<< 1;
      else if (!b_lo && !b_hi) term = -(c_ext <<< 1);
    end else begin
      case ({b_lo, b_hi})
        2'b11:   term = c_ext <<< 1;
        2'b00:   term = '0;
        default: term = c_ext;
      endcase
    end
  end

  // Round half up through an arithmetic shift, then clip to the output range.
  always_comb begin
    acc_ext = RW'(acc);
    rnd_sum = acc_ext + RND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > SAT_MAX)      sat = SAT_MAX[DOUT_W-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[DOUT_W-1:0];
    else                        sat = shifted[DOUT_W-1:0];
  end

  // Datapath
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      line   <= '0;
      snap   <= '0;
      acc    <= '0;
      k      <= '0;
      result <= '0;
      Dout   <= '0;
      Push   <= 1'b0;
      for (int i = 0; i < NC; i++) coef[i] <= '0;
    end else begin
      Push <= 1'b0;
      // The line keeps shifting in every state. LOAD captures the value
      // from before this edge's shift.
      if (BitValid) line <= {line[TAPS-2:0], BitIn};
      if (CoefWe && !Busy && ({1'b0, CoefAddr} < NC_V)) coef[CoefAddr] <= CoefData;
      case (state)
        S_LOAD: begin
          snap <= line;
          acc  <= '0;
          k    <= '0;
        end
        S_CALC: begin
          acc <= acc + term;
          k   <= k + 1'b1;
        end
        S_ROUND: result <= sat;
        S_OUT: begin
          Dout <= result;
          Push <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_fir_bs.sv
// tb_sym_fir_bs -- bench for sym_fir_bs with TAPS=8.
// Three instances share the inputs: unipolar with SHIFT=0, bipolar with
// SHIFT=0, and bipolar with SHIFT=2. The reference treats the filter as a
// full TAPS-long sum over a queue of bits, using mirrored coefficients and
// 64-bit arithmetic.
module tb_sym_fir_bs;

  localparam int TAPS = 8;
  localparam int NC   = 4;

  // clock / reset
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic               BitIn = 1'b0, BitValid = 1'b0, FILTER = 1'b0, CoefWe = 1'b0;
  logic [1:0]         CoefAddr = '0;
  logic signed [15:0] CoefData = '0;
  logic signed [15:0] dout_u, dout_b, dout_s;
  logic               push_u, push_b, push_s, busy_u, busy_b, busy_s;
  logic [2:0]         st_u, st_b, st_s;

  sym_fir_bs #(.TAPS(TAPS), .COEF_W(16), .DOUT_W(16), .SHIFT(0), .BIPOLAR(0)) u_uni (
    .Clock(Clock), .Reset(Reset), .BitIn(BitIn), .BitValid(BitValid), .FILTER(FILTER),
    .CoefWe(CoefWe), .CoefAddr(CoefAddr), .CoefData(CoefData),
    .Dout(dout_u), .Push(push_u), .Busy(busy_u), .dbg_state(st_u));
  sym_fir_bs #(.TAPS(TAPS), .COEF_W(16), .DOUT_W(16), .SHIFT(0), .BIPOLAR(1)) u_bip (
    .Clock(Clock), .Reset(Reset), .BitIn(BitIn), .BitValid(BitValid), .FILTER(FILTER),
    .CoefWe(CoefWe), .CoefAddr(CoefAddr), .CoefData(CoefData),
    .Dout(dout_b), .Push(push_b), .Busy(busy_b), .dbg_state(st_b));
  sym_fir_bs #(.TAPS(TAPS), .COEF_W(16), .DOUT_W(16), .SHIFT(2), .BIPOLAR(1)) u_bs2 (
    .Clock(Clock), .Reset(Reset), .BitIn(BitIn), .BitValid(BitValid), .FILTER(FILTER),
    .CoefWe(CoefWe), .CoefAddr(CoefAddr), .CoefData(CoefData),
    .Dout(dout_s), .Push(push_s), .Busy(busy_s), .dbg_state(st_s));

  // scoreboard state
  int          total = 0;
  int          bad   = 0;
  int          coef_m[NC];
  bit          mline[$];           // mline[0] is the newest bit
  int          push_cnt = 0;
  logic [15:0] exp_q[$];           // expected results u, b, s per run

  typedef struct {
    logic signed [15:0] dout_u, dout_b, dout_s;
    int   lat;
    logic busy_first, busy_push, push_all, push_after, busy_after;
  } obs_t;

  // Reference sample line
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mline.delete();
      for (int i = 0; i < TAPS; i++) mline.push_back(1'b0);
    end else if (BitValid) begin
      mline.push_front(BitIn);
      void'(mline.pop_back());
    end
  end

  always @(posedge Clock) if (push_b) push_cnt++;

  // Reference model: y = sum_i h[i]*x(s[i]), h mirrored from c, then round and clip.
  function automatic longint model_y(input bit bip, input int sh);
    longint y;
    y = 0;
    for (int i = 0; i < TAPS; i++) begin
      int h;
      int x;
      h = coef_m[(i < NC) ? i : TAPS - 1 - i];
      x = bip ? (mline[i] ? 1 : -1) : (mline[i] ? 1 : 0);
      y += longint'(h) * longint'(x);
    end
    if (sh > 0) y = (y + (longint'(1) << (sh - 1))) >>> sh;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  // driver tasks (each starts and ends just after a falling edge)
  task automatic write_coef(input int a, input int d);
    CoefWe = 1'b1; CoefAddr = 2'(a); CoefData = 16'(d);
    @(posedge Clock); @(negedge Clock);
    CoefWe = 1'b0;
    coef_m[a] = d;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      BitValid = 1'b1; BitIn = bits[i];
      @(posedge Clock); @(negedge Clock);
    end
    BitValid = 1'b0;
  endtask

  // One run. poke re-pulses FILTER and writes c[0] two cycles into CALC,
  // and raises FILTER again during the Push cycle.
  task automatic run_filter(input bit toggle, input bit poke, input bit same_we,
                            input int waddr, input int wdata, output obs_t o);
    int edges;
    FILTER = 1'b1;
    if (same_we) begin
      CoefWe = 1'b1; CoefAddr = 2'(waddr); CoefData = 16'(wdata);
      coef_m[waddr] = wdata;
    end
    BitValid = toggle; BitIn = 1'($urandom);
    @(posedge Clock); @(negedge Clock);
    FILTER = 1'b0; CoefWe = 1'b0;
    exp_q.push_back(16'(model_y(1'b0, 0)));
    exp_q.push_back(16'(model_y(1'b1, 0)));
    exp_q.push_back(16'(model_y(1'b1, 2)));
    o.busy_first = busy_u & busy_b & busy_s;
    edges = 0;
    while (!(push_u | push_b | push_s) && edges < 20) begin
      FILTER   = poke && (edges == 3);
      CoefWe   = poke && (edges == 3);
      CoefAddr = 2'd0;
      CoefData = 16'sh7000;
      BitValid = toggle; BitIn = 1'($urandom);
      @(posedge Clock); edges++; @(negedge Clock);
    end
    CoefWe      = 1'b0;
    o.lat       = edges;
    o.push_all  = push_u & push_b & push_s;
    o.busy_push = busy_u & busy_b & busy_s;
    o.dout_u    = dout_u; o.dout_b = dout_b; o.dout_s = dout_s;
    FILTER   = poke;
    BitValid = 1'b0;
    @(posedge Clock); @(negedge Clock);
    FILTER = 1'b0;
    o.push_after = push_u | push_b | push_s;
    o.busy_after = busy_u | busy_b | busy_s;
  endtask

  // scenarios
  task automatic test_reset();
    obs_t o;
    logic [15:0] eu, eb, es;
    int p;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    total++;
    if ({dout_u, dout_b, dout_s, push_u, push_b, push_s, busy_u, busy_b, busy_s} !== '0) begin
      bad++; $display("FAIL reset_outputs got %0d/%0d/%0d push=%b%b%b busy=%b%b%b want 0",
        dout_u, dout_b, dout_s, push_u, push_b, push_s, busy_u, busy_b, busy_s);
    end
    Reset = 1'b0;
    for (int i = 0; i < NC; i++) write_coef(i, i + 1);
    shift_bits(32'hFF, 8);
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es}) begin
      bad++; $display("FAIL pre_reset_run got %0d/%0d/%0d want %0d/%0d/%0d",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
    // start a run, then reset in the middle of CALC
    FILTER = 1'b1;
    @(posedge Clock); @(negedge Clock);
    FILTER = 1'b0;
    repeat (3) begin @(posedge Clock); @(negedge Clock); end
    p = push_cnt;
    Reset = 1'b1;
    #1;
    total++;
    if ({dout_u, dout_b, dout_s, push_u, push_b, push_s, busy_u, busy_b, busy_s, st_b} !== '0) begin
      bad++; $display("FAIL mid_reset got %0d/%0d/%0d push=%b%b%b busy=%b%b%b st=%0d want 0",
        dout_u, dout_b, dout_s, push_u, push_b, push_s, busy_u, busy_b, busy_s, st_b);
    end
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < NC; i++) coef_m[i] = 0;
    repeat (12) @(negedge Clock);
    total++;
    if (push_cnt !== p) begin
      bad++; $display("FAIL reset_no_push pushes=%0d want %0d", push_cnt, p);
    end
    for (int i = 0; i < NC; i++) write_coef(i, i + 1);
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es}) begin
      bad++; $display("FAIL zero_line_model got %0d/%0d/%0d want %0d/%0d/%0d",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
    total++;
    if ({o.dout_u, o.dout_b} !== {16'sd0, -16'sd20}) begin
      bad++; $display("FAIL zero_line_const got %0d/%0d want 0/-20", o.dout_u, o.dout_b);
    end
  endtask

  task automatic test_ones();
    obs_t o;
    logic [15:0] eu, eb, es;
    shift_bits(32'hFF, 8);
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} || o.dout_u !== 16'sd20) begin
      bad++; $display("FAIL ones_dout got %0d/%0d/%0d want %0d/%0d/%0d (uni 20)",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
    total++;
    if (o.lat !== NC + 3) begin
      bad++; $display("FAIL ones_latency got %0d want %0d", o.lat, NC + 3);
    end
    total++;
    if ({o.busy_first, o.busy_push, o.push_all, o.push_after, o.busy_after} !== 5'b11100) begin
      bad++; $display("FAIL ones_strobes busy_first=%b busy_push=%b push=%b push_after=%b busy_after=%b want 1 1 1 0 0",
        o.busy_first, o.busy_push, o.push_all, o.push_after, o.busy_after);
    end
  endtask

  task automatic test_single();
    obs_t o;
    logic [15:0] eu, eb, es;
    shift_bits(32'h80, 8);
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} ||
        {o.dout_b, o.dout_s} !== {-16'sd18, -16'sd4}) begin
      bad++; $display("FAIL single_bit got %0d/%0d/%0d want %0d/%0d/%0d (bip -18, shift2 -4)",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
  endtask

  task automatic test_saturation();
    obs_t o;
    logic [15:0] eu, eb, es;
    for (int i = 0; i < NC; i++) write_coef(i, 32767);
    shift_bits(32'hFF, 8);
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} || o.dout_b !== 16'sd32767) begin
      bad++; $display("FAIL sat_high got %0d/%0d/%0d want %0d/%0d/%0d",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
    shift_bits(32'h0, 8);
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} || o.dout_b !== -16'sd32768) begin
      bad++; $display("FAIL sat_low got %0d/%0d/%0d want %0d/%0d/%0d",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] eu, eb, es;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NC; i++) begin
        int v;
        v = $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) - 32768
                                 : int'($urandom_range(0, 600)) - 300;
        write_coef(i, v);
      end
      shift_bits($urandom, int'($urandom_range(1, 10)));
      run_filter(1'($urandom), 1'b0, 1'($urandom), int'($urandom_range(0, NC - 1)),
                 int'($urandom_range(0, 600)) - 300, o);
      eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
      total++;
      if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} || o.lat !== NC + 3) begin
        bad++; $display("FAIL random_%0d got %0d/%0d/%0d lat=%0d want %0d/%0d/%0d lat=%0d", it,
          o.dout_u, o.dout_b, o.dout_s, o.lat, $signed(eu), $signed(eb), $signed(es), NC + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [15:0] eu, eb, es;
    int p;
    for (int i = 0; i < NC; i++) write_coef(i, 10 * (i + 1) - 7);
    shift_bits(32'hFF, 8);
    p = push_cnt;
    run_filter(1'b0, 1'b1, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} || o.lat !== NC + 3 ||
        o.push_after !== 1'b0 || o.busy_after !== 1'b0) begin
      bad++; $display("FAIL busy_ignore got %0d/%0d/%0d lat=%0d pa=%b ba=%b want %0d/%0d/%0d lat=%0d 0 0",
        o.dout_u, o.dout_b, o.dout_s, o.lat, o.push_after, o.busy_after,
        $signed(eu), $signed(eb), $signed(es), NC + 3);
    end
    // FILTER in the cycle after Push; c[0] must still hold its earlier value
    run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es} || o.busy_first !== 1'b1) begin
      bad++; $display("FAIL after_push_run got %0d/%0d/%0d busy=%b want %0d/%0d/%0d busy=1",
        o.dout_u, o.dout_b, o.dout_s, o.busy_first, $signed(eu), $signed(eb), $signed(es));
    end
    total++;
    if (push_cnt !== p + 2) begin
      bad++; $display("FAIL push_count got %0d want %0d", push_cnt - p, 2);
    end
    // a write in the same cycle as FILTER is used by that run
    run_filter(1'b0, 1'b0, 1'b1, 2, -1234, o);
    eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
    total++;
    if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es}) begin
      bad++; $display("FAIL same_cycle_write got %0d/%0d/%0d want %0d/%0d/%0d",
        o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
    end
  endtask

  task automatic test_shift_during();
    obs_t o;
    logic [15:0] eu, eb, es;
    for (int r = 0; r < 3; r++) begin
      shift_bits($urandom, 8);
      run_filter(1'b1, 1'b0, 1'b0, 0, 0, o);
      eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
      total++;
      if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es}) begin
        bad++; $display("FAIL shift_during_%0d got %0d/%0d/%0d want %0d/%0d/%0d", r,
          o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
      end
      run_filter(1'b0, 1'b0, 1'b0, 0, 0, o);
      eu = exp_q.pop_front(); eb = exp_q.pop_front(); es = exp_q.pop_front();
      total++;
      if ({o.dout_u, o.dout_b, o.dout_s} !== {eu, eb, es}) begin
        bad++; $display("FAIL shift_next_%0d got %0d/%0d/%0d want %0d/%0d/%0d", r,
          o.dout_u, o.dout_b, o.dout_s, $signed(eu), $signed(eb), $signed(es));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_ones();
    test_single();
    test_saturation();
    test_random();
    test_back_to_back();
    test_shift_during();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
